// File: rtl/tdm_demux_1_4_if.sv
// Bundle between a serial TDM stream source and the 1:4 demultiplexer.
// master = stream source / consumer of recovered words, slave = demux.
interface tdm_demux_1_4_if #(
    parameter int WIDTH = 4
);
    logic             din;
    logic             sync;
    logic [WIDTH-1:0] ch_a;
    logic [WIDTH-1:0] ch_b;
    logic [WIDTH-1:0] ch_c;
    logic [WIDTH-1:0] ch_d;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;
    logic             parity_err;

    modport master (
        output din,
        output sync,
        input  ch_a,
        input  ch_b,
        input  ch_c,
        input  ch_d,
        input  frame_valid,
        input  locked,
        input  sync_err,
        input  parity_err
    );

    modport slave (
        input  din,
        input  sync,
        output ch_a,
        output ch_b,
        output ch_c,
        output ch_d,
        output frame_valid,
        output locked,
        output sync_err,
        output parity_err
    );
endinterface

// File: rtl/tdm_demux_1_4.sv
// 1:4 TDM demultiplexer with flywheel frame lock and misaligned-sync detection.
// Define TDM_DEMUX_PARITY_EN to add one even-parity bit per slot and parity_err.
module tdm_demux_1_4 #(
    parameter int WIDTH      = 4,
    parameter int MISS_LIMIT = 2
) (
    input  logic            clk,
    input  logic            rst,
    tdm_demux_1_4_if.slave  bus
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT = WIDTH + 1;
`else
    localparam int SLOT = WIDTH;
`endif
    localparam int FRAME = 4 * SLOT;
    localparam int CW    = $clog2(FRAME);
    localparam int MW    = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;

    localparam logic [CW-1:0] LAST     = CW'(FRAME - 1);
    localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT - 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [MW-1:0]    r_miss;
    logic [MW-1:0]    w_miss_nxt;
    logic [FRAME-2:0] r_shift;
    logic [FRAME-1:0] w_frame;
    logic             w_load;
    logic             w_serr;

    logic [WIDTH-1:0] w_data [4];
    logic [WIDTH-1:0] r_ch   [4];
    logic             r_fv;
    logic             r_locked;
    logic             r_serr;

    // The current bit completes the frame held in the shift register.
    assign w_frame = {r_shift, bus.din};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_data[k] = w_frame[FRAME-1-k*SLOT -: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_miss_nxt  = r_miss;
        w_load      = 1'b0;
        w_serr      = 1'b0;
        unique case (r_state)
            HUNT: begin
                w_cnt_nxt  = '0;
                w_miss_nxt = '0;
                if (bus.sync) begin
                    w_state_nxt = LOCK;
                    w_cnt_nxt   = CW'(1);
                end
            end
            LOCK: begin
                w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
                if (bus.sync) begin
                    // Off-boundary sync realigns; this bit becomes bit 0.
                    w_miss_nxt = '0;
                    if (r_cnt != '0) begin
                        w_serr    = 1'b1;
                        w_cnt_nxt = CW'(1);
                    end
                end else if (r_cnt == '0) begin
                    if (r_miss == MISS_MAX) begin
                        w_state_nxt = HUNT;
                        w_cnt_nxt   = '0;
                        w_miss_nxt  = '0;
                    end else begin
                        w_miss_nxt = r_miss + MW'(1);
                    end
                end else if (r_cnt == LAST) begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_miss   <= '0;
            r_shift  <= '0;
            r_fv     <= 1'b0;
            r_locked <= 1'b0;
            r_serr   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_ch[k] <= '0;
            end
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_miss   <= w_miss_nxt;
            r_shift  <= w_frame[FRAME-2:0];
            r_fv     <= w_load;
            r_locked <= (w_state_nxt == LOCK);
            r_serr   <= w_serr;
            if (w_load) begin
                for (int k = 0; k < 4; k++) begin
                    r_ch[k] <= w_data[k];
                end
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic [3:0] w_pbad;
    logic       r_perr;

    // Even parity: XOR over data plus parity bit must be zero.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_pbad[k] = ^w_frame[FRAME-1-k*SLOT -: SLOT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_load & (|w_pbad);
        end
    end

    assign bus.parity_err = r_perr;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.ch_a        = r_ch[0];
    assign bus.ch_b        = r_ch[1];
    assign bus.ch_c        = r_ch[2];
    assign bus.ch_d        = r_ch[3];
    assign bus.frame_valid = r_fv;
    assign bus.locked      = r_locked;
    assign bus.sync_err    = r_serr;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed and random stimulus for tdm_demux_1_4 against a queue-based model.
// The model collects stream bits per frame and decodes slots arithmetically.
module tb_tdm_demux_1_4;
    localparam int WIDTH      = 4;
    localparam int MISS_LIMIT = 2;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT = WIDTH + 1;
`else
    localparam int SLOT = WIDTH;
`endif
    localparam int FRAME = 4 * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdm_demux_1_4_if #(.WIDTH(WIDTH)) bus ();

    tdm_demux_1_4 #(
        .WIDTH      (WIDTH),
        .MISS_LIMIT (MISS_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int               n_assert = 0;
    int               n_fail   = 0;
    bit               m_lock;
    int               m_miss;
    bit               q[$];
    logic [WIDTH-1:0] m_ch[4];
    logic             m_fv;
    logic             m_se;
    logic             m_pe;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
        chk("locked", 32'(bus.locked), 32'(m_lock));
        chk("sync_err", 32'(bus.sync_err), 32'(m_se));
        chk("parity_err", 32'(bus.parity_err), 32'(m_pe));
        chk("ch_a", 32'(bus.ch_a), 32'(m_ch[0]));
        chk("ch_b", 32'(bus.ch_b), 32'(m_ch[1]));
        chk("ch_c", 32'(bus.ch_c), 32'(m_ch[2]));
        chk("ch_d", 32'(bus.ch_d), 32'(m_ch[3]));
    endtask

    task automatic model_reset();
        m_lock = 1'b0;
        m_miss = 0;
        q.delete();
        m_fv = 1'b0;
        m_se = 1'b0;
        m_pe = 1'b0;
        for (int k = 0; k < 4; k++) m_ch[k] = '0;
    endtask

    // Expected outputs for the cycle after a bit with these inputs.
    task automatic model_step(input bit din, input bit sync);
        m_fv = 1'b0;
        m_se = 1'b0;
        m_pe = 1'b0;
        if (!m_lock) begin
            if (sync) begin
                m_lock = 1'b1;
                m_miss = 0;
                q.delete();
                q.push_back(din);
            end
        end else if (sync) begin
            if (q.size() != 0) m_se = 1'b1;
            q.delete();
            q.push_back(din);
            m_miss = 0;
        end else if (q.size() == 0 && m_miss + 1 >= MISS_LIMIT) begin
            m_lock = 1'b0;
            m_miss = 0;
        end else begin
            if (q.size() == 0) m_miss++;
            q.push_back(din);
        end
        if (m_lock && q.size() == FRAME) begin
            for (int k = 0; k < 4; k++) begin
                logic [WIDTH-1:0] d;
                d = '0;
                for (int j = 0; j < WIDTH; j++) d = {d[WIDTH-2:0], q[k*SLOT+j]};
                m_ch[k] = d;
`ifdef TDM_DEMUX_PARITY_EN
                begin
                    bit p;
                    p = 1'b0;
                    for (int j = 0; j < SLOT; j++) p ^= q[k*SLOT+j];
                    if (p) m_pe = 1'b1;
                end
`endif
            end
            m_fv = 1'b1;
            q.delete();
        end
    endtask

    task automatic cyc(input bit din, input bit sync);
        bus.din  = din;
        bus.sync = sync;
        model_step(din, sync);
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [FRAME-1:0] mk(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c,
                                            input logic [WIDTH-1:0] d,
                                            input logic [3:0] flip);
        logic [WIDTH-1:0] w[4];
        logic [FRAME-1:0] f;
        f = '0;
        w[0] = a;
        w[1] = b;
        w[2] = c;
        w[3] = d;
        for (int k = 0; k < 4; k++) begin
`ifdef TDM_DEMUX_PARITY_EN
            f = {f[FRAME-SLOT-1:0], w[k], (^w[k]) ^ flip[k]};
`else
            f = {f[FRAME-SLOT-1:0], w[k] ^ {WIDTH{flip[k] & 1'b0}}};
`endif
        end
        return f;
    endfunction

    function automatic logic [FRAME-1:0] rnd_frame();
        return mk(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                  WIDTH'($urandom), 4'b0000);
    endfunction

    task automatic send_frame(input logic [FRAME-1:0] f, input bit s);
        for (int i = 0; i < FRAME; i++) cyc(f[FRAME-1-i], s && (i == 0));
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        model_reset();
        bus.din  = 1'b0;
        bus.sync = 1'b0;
        rst      = 1'b1;
        #12;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Known pattern with sync at bit 0
        send_frame(mk(4'b1010, 4'b0110, 4'b1100, 4'b0011, 4'b0000), 1'b1);

        // Back-to-back frames
        for (int i = 0; i < 3; i++) send_frame(rnd_frame(), 1'b1);

        // One missing sync keeps decoding, two consecutive drop lock
        send_frame(rnd_frame(), 1'b0);
        send_frame(rnd_frame(), 1'b1);
        send_frame(rnd_frame(), 1'b0);
        send_frame(rnd_frame(), 1'b0);
        send_bits(9);

        // Relock, then misaligned sync at bit 5
        send_frame(rnd_frame(), 1'b1);
        cyc(1'($urandom_range(0, 1)), 1'b1);
        send_bits(4);
        send_frame(rnd_frame(), 1'b1);
        send_frame(rnd_frame(), 1'b1);

        // Sync on the last bit of a frame beats the frame load
        cyc(1'($urandom_range(0, 1)), 1'b1);
        send_bits(FRAME - 2);
        send_frame(rnd_frame(), 1'b1);

        // Asynchronous reset in the middle of a frame
        cyc(1'($urandom_range(0, 1)), 1'b1);
        send_bits(7);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_bits(10);
        send_frame(rnd_frame(), 1'b1);

`ifdef TDM_DEMUX_PARITY_EN
        send_frame(mk(4'b1001, 4'b0111, 4'b1101, 4'b0010, 4'b0100), 1'b1);
        send_frame(mk(4'b1001, 4'b0111, 4'b1101, 4'b0010, 4'b0000), 1'b1);
`endif

        // Random stream: mostly aligned syncs with occasional stray ones
        for (int k = 0; k < 480; k++) begin
            bit s;
            if (k % FRAME == 0) s = ($urandom_range(0, 7) != 0);
            else                s = ($urandom_range(0, 39) == 0);
            cyc(1'($urandom_range(0, 1)), s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
